multi_blinker: RTL and testbench

Parametrised successor to the single-channel programmable blinker. It drives `CHANNELS` independent LED outputs. Each channel has a shift-programmable one-hot blink rate and a programmable burst of 1..`MAX_FLASH` flashes per period. The block is paced by the shared beat tick `count_en` and sits between the button/debounce front end and the LED pins. A synchronous `restart` phase-aligns all channels.

---
 rtl/blink_pkg.sv | 22 ++
 rtl/blink_channel.sv | 87 ++++++++
 rtl/multi_blinker.sv | 58 +++++
 tb/tb_multi_blinker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared helpers for the multi-channel blinker: reset rate value and derived field widths.
// Pure elaboration-time functions; no logic, no latency, no flow control.
package blink_pkg;

   function automatic int rate_rst(input int rate_w);
      return 1 << (rate_w / 2);
   endfunction

   function automatic int flash_w(input int max_flash);
      return $clog2(max_flash + 1);
   endfunction

   // Phase runs 0..2F+1, so 2*MAX_FLASH+2 distinct values.
   function automatic int phase_w(input int max_flash);
      return $clog2(2 * max_flash + 2);
   endfunction

   function automatic int sel_w(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: one-hot rate, beat timer, flash/gap phase counter and pending flash count.
// Writes and beats land on the next edge; led is decoded from registered state; never stalls.
module blink_channel
   import blink_pkg::*;
#(
   parameter int RATE_W    = 4,
   parameter int MAX_FLASH = 4,
   localparam int FLASH_W  = flash_w(MAX_FLASH),
   localparam int PHASE_W  = phase_w(MAX_FLASH)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_count_en,
   input  logic               i_restart,
   input  logic               i_shl,
   input  logic               i_shr,
   input  logic               i_flash_wr,
   input  logic [FLASH_W-1:0] i_flash_val,
   output logic               o_led,
   output logic [RATE_W-1:0]  o_rate
);

   localparam logic [RATE_W-1:0]  RATE_RST  = RATE_W'(rate_rst(RATE_W));
   localparam logic [FLASH_W-1:0] FLASH_MAX = FLASH_W'(MAX_FLASH);

   logic [RATE_W-1:0]  r_rate;
   logic [RATE_W-1:0]  r_timer;
   logic [PHASE_W-1:0] r_phase;
   logic [FLASH_W-1:0] r_f_act;
   logic [FLASH_W-1:0] r_f_pend;

   logic [RATE_W-1:0]  w_rate_nxt;
   logic [FLASH_W-1:0] w_flash_clamped;
   logic [PHASE_W-1:0] w_gap_start;
   logic [PHASE_W-1:0] w_phase_last;

   assign w_gap_start     = {r_f_act, 1'b0};
   assign w_phase_last    = {r_f_act, 1'b1};
   assign w_flash_clamped = (i_flash_val > FLASH_MAX) ? FLASH_MAX : i_flash_val;

   // Opposing shifts cancel; each direction saturates at its end bit.
   always_comb begin
      w_rate_nxt = r_rate;
      if (i_shl && !i_shr && !r_rate[RATE_W-1]) begin
         w_rate_nxt = r_rate << 1;
      end else if (i_shr && !i_shl && !r_rate[0]) begin
         w_rate_nxt = r_rate >> 1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rate   <= RATE_RST;
         r_timer  <= RATE_RST;
         r_phase  <= '0;
         r_f_act  <= FLASH_W'(1);
         r_f_pend <= FLASH_W'(1);
      end else begin
         r_rate <= w_rate_nxt;
         if (i_flash_wr) begin
            r_f_pend <= w_flash_clamped;
         end
         // Timer reloads use the pre-shift rate, so a shift only shows at the next boundary.
         if (i_restart) begin
            r_phase <= '0;
            r_timer <= r_rate;
            r_f_act <= r_f_pend;
         end else if (i_count_en) begin
            if (r_timer == RATE_W'(1)) begin
               r_timer <= r_rate;
               if (r_phase == w_phase_last) begin
                  r_phase <= '0;
                  r_f_act <= r_f_pend;
               end else begin
                  r_phase <= r_phase + PHASE_W'(1);
               end
            end else begin
               r_timer <= r_timer - RATE_W'(1);
            end
         end
      end
   end

   assign o_led  = (r_f_act != '0) && !r_phase[0] && (r_phase < w_gap_start);
   assign o_rate = r_rate;

endmodule

// File: rtl/multi_blinker.sv
// CHANNELS independent programmable blinkers sharing one beat tick, with a common phase restart.
// Writes and beats take effect on the next edge; cur_rate is a combinational mux; never stalls.
module multi_blinker
   import blink_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int RATE_W    = 4,
   parameter int MAX_FLASH = 4,
   localparam int SEL_W    = sel_w(CHANNELS),
   localparam int FLASH_W  = flash_w(MAX_FLASH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                count_en,
   input  logic [SEL_W-1:0]    sel,
   input  logic                shift_left,
   input  logic                shift_right,
   input  logic                flash_wr,
   input  logic [FLASH_W-1:0]  flash_val,
   input  logic                restart,
   output logic [CHANNELS-1:0] led,
   output logic [RATE_W-1:0]   cur_rate
);

   logic [RATE_W-1:0]   w_rate [CHANNELS];
   logic [CHANNELS-1:0] w_sel_hit;

   // An out-of-range sel matches no channel: writes drop and cur_rate reads zero.
   always_comb begin
      w_sel_hit = '0;
      cur_rate  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel == SEL_W'(i)) begin
            w_sel_hit[i] = 1'b1;
            cur_rate     = w_rate[i];
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      blink_channel #(
         .RATE_W    (RATE_W),
         .MAX_FLASH (MAX_FLASH)
      ) u_ch (
         .i_clk       (clk),
         .i_rst_n     (rst),
         .i_count_en  (count_en),
         .i_restart   (restart),
         .i_shl       (shift_left  & w_sel_hit[g]),
         .i_shr       (shift_right & w_sel_hit[g]),
         .i_flash_wr  (flash_wr    & w_sel_hit[g]),
         .i_flash_val (flash_val),
         .o_led       (led[g]),
         .o_rate      (w_rate[g])
      );
   end

endmodule

// File: tb/tb_multi_blinker.sv
// Directed bench for multi_blinker: default 4-channel instance plus a 3-channel instance on shared stimulus.
// Expected waveforms are queued by the stimulus process and checked by an independent monitor.
module tb_multi_blinker;

    logic       clk = 1'b0;
    logic       rst;
    logic       count_en;
    logic [1:0] sel;
    logic       shift_left;
    logic       shift_right;
    logic       flash_wr;
    logic [2:0] flash_val;
    logic       restart;
    logic [3:0] led;
    logic [3:0] cur_rate;
    logic [2:0] led3;
    logic [3:0] cur_rate3;

    typedef struct {
        string      name;
        int         kind;
        logic [3:0] exp;
    } item_t;

    item_t q[$];
    event  chk_ev;
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    multi_blinker u_dut (
        .clk         (clk),
        .rst         (rst),
        .count_en    (count_en),
        .sel         (sel),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .flash_wr    (flash_wr),
        .flash_val   (flash_val),
        .restart     (restart),
        .led         (led),
        .cur_rate    (cur_rate)
    );

    multi_blinker #(.CHANNELS(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .count_en    (count_en),
        .sel         (sel),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .flash_wr    (flash_wr),
        .flash_val   (flash_val),
        .restart     (restart),
        .led         (led3),
        .cur_rate    (cur_rate3)
    );

    // Monitor: drains every queued expectation at each sample point.
    initial begin
        item_t      it;
        logic [3:0] got;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                it = q.pop_front();
                case (it.kind)
                    0:       got = led;
                    1:       got = cur_rate;
                    2:       got = {1'b0, led3};
                    default: got = cur_rate3;
                endcase
                n_tests++;
                if (got !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Closed-form LED waveform: m beats after entering phase 0, F flashes, rate r.
    function automatic bit wave(input int m, input int f, input int r);
        int per;
        per = (2 * f + 2) * r;
        if (m < 0) return 1'b0;
        return ((m % per) < (2 * f * r)) && (((m / r) % 2) == 0);
    endfunction

    task automatic push(input string nm, input int kind, input logic [3:0] e);
        item_t it;
        it.name = nm;
        it.kind = kind;
        it.exp  = e;
        q.push_back(it);
    endtask

    task automatic expect_all(input string tag, input int k, input logic [3:0] el, input logic [3:0] er);
        push($sformatf("%s k=%0d led", tag, k), 0, el);
        push($sformatf("%s k=%0d cur_rate", tag, k), 1, er);
        push($sformatf("%s k=%0d led3", tag, k), 2, {1'b0, el[2:0]});
        push($sformatf("%s k=%0d cur_rate3", tag, k), 3, (sel == 2'd3) ? 4'd0 : er);
        -> chk_ev;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] el;
        logic [3:0] er;
        bit         w;
        rst         = 1'b0;
        count_en    = 1'b1;
        sel         = 2'd0;
        shift_left  = 1'b0;
        shift_right = 1'b0;
        flash_wr    = 1'b0;
        flash_val   = 3'd0;
        restart     = 1'b0;

        adv();
        expect_all("reset", 0, 4'hF, 4'd4);
        n_tests++;
        if (led !== 4'hF) begin
            n_fail++;
            $display("FAIL reset direct led: got %b", led);
        end
        n_tests++;
        if (cur_rate !== 4'd4) begin
            n_fail++;
            $display("FAIL reset direct cur_rate: got %0d", cur_rate);
        end
        n_tests++;
        if (led3 !== 3'b111) begin
            n_fail++;
            $display("FAIL reset direct led3: got %b", led3);
        end
        #2 rst = 1'b1;

        // 4 high / 12 low, period 16, on every channel.
        for (int k = 1; k <= 32; k++) begin
            adv();
            el = {4{wave(k, 1, 4)}};
            expect_all("rst_wave", k, el, 4'd4);
        end

        // Rate saturation on channel 1; new rate only shows after the running phase ends.
        sel = 2'd1;
        for (int k = 33; k <= 52; k++) begin
            shift_right = ((k >= 33) && (k <= 35)) || (k == 45);
            shift_left  = (k >= 40) && (k <= 45);
            adv();
            w  = wave(k, 1, 4);
            el = {w, w, ((k <= 35) || (k == 39) || (k >= 51)), w};
            er = (k == 33) ? 4'd2 : (k <= 39) ? 4'd1 : (k == 40) ? 4'd2 : (k == 41) ? 4'd4 : 4'd8;
            expect_all("rate", k, el, er);
        end
        shift_left  = 1'b0;
        shift_right = 1'b0;

        // Pending flash counts: ch3 <- 7 (clamps to 4), ch2 <- 3 at beat 6, ch0 <- 0.
        for (int k = 53; k <= 104; k++) begin
            flash_wr  = (k <= 55);
            sel       = (k == 53) ? 2'd3 : (k == 54) ? 2'd2 : 2'd0;
            flash_val = (k == 53) ? 3'd7 : (k == 54) ? 3'd3 : 3'd0;
            adv();
            el[0] = (k < 64) ? wave(k, 1, 4) : 1'b0;
            el[1] = wave(k - 51, 1, 8);
            el[2] = (k < 64) ? wave(k, 1, 4) : wave(k - 64, 3, 4);
            el[3] = (k < 64) ? wave(k, 1, 4) : wave(k - 64, 4, 4);
            expect_all("flash", k, el, 4'd4);
        end
        flash_wr  = 1'b0;
        flash_val = 3'd0;

        // Restart with a same-cycle shift on ch1; then an out-of-range shift for the 3-channel part.
        for (int k = 105; k <= 131; k++) begin
            restart     = (k == 105);
            shift_right = (k == 105);
            shift_left  = (k == 131);
            sel         = (k >= 131) ? 2'd3 : 2'd1;
            adv();
            el[0] = 1'b0;
            el[1] = (k <= 112) || ((k >= 125) && (k <= 128));
            el[2] = wave(k - 105, 3, 4);
            el[3] = wave(k - 105, 4, 4);
            expect_all("restart", k, el, (k == 131) ? 4'd8 : 4'd4);
        end
        restart     = 1'b0;
        shift_right = 1'b0;
        shift_left  = 1'b0;

        // Asynchronous reset between edges, then a fresh start with no leftover writes.
        #2 rst = 1'b0;
        #1;
        expect_all("async_rst", 131, 4'hF, 4'd4);
        n_tests++;
        if (led !== 4'hF) begin
            n_fail++;
            $display("FAIL async_rst direct led: got %b", led);
        end
        n_tests++;
        if (cur_rate3 !== 4'd0) begin
            n_fail++;
            $display("FAIL async_rst direct cur_rate3: got %0d", cur_rate3);
        end
        n_tests++;
        if (cur_rate !== 4'd4) begin
            n_fail++;
            $display("FAIL async_rst direct cur_rate: got %0d", cur_rate);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            adv();
            el = {4{wave(j, 1, 4)}};
            expect_all("post_rst", j, el, 4'd4);
        end

        #1;
        if (n_tests < 12) begin
            $display("FAIL too few tests ran: %0d", n_tests);
        end
        if (n_fail != 0) begin
            $display("FAIL %0d checks failed", n_fail);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
